// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM state encoding,
// the hard-wired zero register and the default multiply/divide timeout.
package hazard_ctrl_pkg;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_EXEC = 1'b1;

    localparam logic [4:0] ZERO_REG = 5'd0;

    localparam int unsigned MD_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Start/done handshake between the hazard controller (master) and the
// multi-cycle multiply/divide unit (slave).
interface hazard_ctrl_if;

    logic md_start;
    logic md_done;

    modport master (output md_start, input md_done);
    modport slave  (input md_start, output md_done);

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the ID source registers and the
// destination of a load sitting in EX.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       use_rs_id,
    input  logic       use_rt_id,
    input  logic [4:0] rw_ex,
    input  logic       wreg_ex,
    input  logic       rmem_ex,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = use_rs_id & (rs_id == rw_ex);
    assign rt_hit   = use_rt_id & (rt_id == rw_ex);
    // Writes to the zero register are discarded, so they never create a hazard.
    assign load_use = rmem_ex & wreg_ex & (rw_ex != ZERO_REG) & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Front-end stall/bubble/flush control for load-use hazards, multi-cycle
// multiply/divide occupancy and ID-resolved redirects.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset_0,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic             md_id,
    input  logic             redirect_id,
    input  logic [4:0]       rw_ex,
    input  logic             wreg_ex,
    input  logic             rmem_ex,
    hazard_ctrl_if.master    md,
    output logic             enable_pc,
    output logic             enable_ifid,
    output logic             enable_idex,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(MD_TIMEOUT - 1);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [7:0] wait_cnt;
    logic       load_use;
    logic       md_issue;
    logic       timeout;

    hazard_detect u_detect (
        .rs_id     (rs_id),
        .rt_id     (rt_id),
        .use_rs_id (use_rs_id),
        .use_rt_id (use_rt_id),
        .rw_ex     (rw_ex),
        .wreg_ex   (wreg_ex),
        .rmem_ex   (rmem_ex),
        .load_use  (load_use)
    );

    always_comb begin
        enable_pc   = 1'b1;
        enable_ifid = 1'b1;
        enable_idex = 1'b1;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        md_issue    = 1'b0;
        timeout     = 1'b0;
        state_nxt   = state;
        if (state == ST_RUN) begin
            if (load_use) begin
                enable_pc   = 1'b0;
                enable_ifid = 1'b0;
                bubble_idex = 1'b1;
            end else begin
                flush_ifid = redirect_id;
                if (md_id) begin
                    md_issue  = 1'b1;
                    state_nxt = ST_MD_EXEC;
                end
            end
        end else if (md.md_done) begin
            state_nxt = ST_RUN;
        end else begin
            enable_pc   = 1'b0;
            enable_ifid = 1'b0;
            enable_idex = 1'b0;
            // The last permitted frozen cycle still holds; release lands on the next edge.
            if (wait_cnt == WAIT_LAST) begin
                timeout   = 1'b1;
                state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            md.md_start <= 1'b0;
            md_error    <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            md.md_start <= md_issue;
            if (md_issue) begin
                wait_cnt <= '0;
            end else if (state == ST_MD_EXEC && !md.md_done) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (timeout) begin
                md_error <= 1'b1;
            end
            if (!enable_pc) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a single-cycle vector table plus hand-written
// multiply, timeout, priority and asynchronous reset sequences.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic       clock = 1'b0;
    logic       reset_0 = 1'b0;
    logic [4:0] rs_id, rt_id, rw_ex;
    logic       use_rs_id, use_rt_id, md_id, redirect_id, wreg_ex, rmem_ex;

    logic        pc_a, ifid_a, idex_a, bub_a, fl_a, err_a;
    logic [31:0] stall_a;
    logic        pc_b, ifid_b, idex_b, bub_b, fl_b, err_b;
    logic [31:0] stall_b;
    logic [4:0]  ctl_a, ctl_b;

    hazard_ctrl_if md_a ();
    hazard_ctrl_if md_b ();

    hazard_ctrl #(.MD_TIMEOUT(64), .CNT_W(32)) dut (
        .clock(clock), .reset_0(reset_0), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .md_id(md_id),
        .redirect_id(redirect_id), .rw_ex(rw_ex), .wreg_ex(wreg_ex),
        .rmem_ex(rmem_ex), .md(md_a), .enable_pc(pc_a), .enable_ifid(ifid_a),
        .enable_idex(idex_a), .bubble_idex(bub_a), .flush_ifid(fl_a),
        .md_error(err_a), .stall_cnt(stall_a)
    );

    hazard_ctrl #(.MD_TIMEOUT(4), .CNT_W(32)) dut_to (
        .clock(clock), .reset_0(reset_0), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .md_id(md_id),
        .redirect_id(redirect_id), .rw_ex(rw_ex), .wreg_ex(wreg_ex),
        .rmem_ex(rmem_ex), .md(md_b), .enable_pc(pc_b), .enable_ifid(ifid_b),
        .enable_idex(idex_b), .bubble_idex(bub_b), .flush_ifid(fl_b),
        .md_error(err_b), .stall_cnt(stall_b)
    );

    assign ctl_a = {pc_a, ifid_a, idex_a, bub_a, fl_a};
    assign ctl_b = {pc_b, ifid_b, idex_b, bub_b, fl_b};

    always #5 clock = ~clock;

    int unsigned checks = 0;
    int unsigned failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rs_id = '0; rt_id = '0; rw_ex = '0;
        use_rs_id = 1'b0; use_rt_id = 1'b0; md_id = 1'b0; redirect_id = 1'b0;
        wreg_ex = 1'b0; rmem_ex = 1'b0;
        md_a.md_done = 1'b0; md_b.md_done = 1'b0;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle();
        reset_0 = 1'b0;
        #2;
        reset_0 = 1'b1;
        next();
    endtask

    typedef struct {
        logic [4:0] rs, rt, rw;
        logic       use_rs, use_rt, wreg, rmem, redirect;
        logic [4:0] exp;   // {enable_pc, enable_ifid, enable_idex, bubble, flush}
    } vec_t;

    vec_t vecs[11];
    int unsigned exp_stall;

    initial begin
        idle();
        vecs[0]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11100};
        vecs[1]  = '{5'd8,  5'd0,  5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00110};
        vecs[2]  = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11100};
        vecs[3]  = '{5'd1,  5'd5,  5'd5,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00110};
        vecs[4]  = '{5'd1,  5'd5,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11100};
        vecs[5]  = '{5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11100};
        vecs[6]  = '{5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11100};
        vecs[7]  = '{5'd3,  5'd4,  5'd9,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'b11101};
        vecs[8]  = '{5'd8,  5'd0,  5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00110};
        vecs[9]  = '{5'd9,  5'd8,  5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11100};
        vecs[10] = '{5'd31, 5'd31, 5'd31, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00110};

        // Reset state with idle inputs
        do_reset();
        @(negedge clock);
        chk("reset_ctl", 64'(ctl_a), 64'(5'b11100));
        chk("reset_md_start", 64'(md_a.md_start), 64'd0);
        chk("reset_md_error", 64'(err_a), 64'd0);
        chk("reset_stall_cnt", 64'(stall_a), 64'd0);

        // Single-cycle vector table, md_id held low
        exp_stall = 0;
        next();
        for (int i = 0; i < 11; i++) begin
            rs_id = vecs[i].rs; rt_id = vecs[i].rt; rw_ex = vecs[i].rw;
            use_rs_id = vecs[i].use_rs; use_rt_id = vecs[i].use_rt;
            wreg_ex = vecs[i].wreg; rmem_ex = vecs[i].rmem;
            redirect_id = vecs[i].redirect;
            @(negedge clock);
            chk($sformatf("vec%0d_ctl", i), 64'(ctl_a), 64'(vecs[i].exp));
            if (!vecs[i].exp[4]) exp_stall++;
            next();
        end
        idle();
        @(negedge clock);
        chk("vec_stall_cnt", 64'(stall_a), 64'(exp_stall));
        chk("vec_no_md_start", 64'(md_a.md_start), 64'd0);

        // Multiply with a 5-cycle unit: done arrives in cycle 5
        do_reset();
        md_id = 1'b1;
        @(negedge clock);
        chk("md_c0_ctl", 64'(ctl_a), 64'(5'b11100));
        next();
        md_id = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            chk($sformatf("md_c%0d_ctl", c), 64'(ctl_a), 64'(5'b00000));
            chk($sformatf("md_c%0d_start", c), 64'(md_a.md_start), 64'(c == 1));
            next();
        end
        md_a.md_done = 1'b1;
        @(negedge clock);
        chk("md_c5_ctl", 64'(ctl_a), 64'(5'b11100));
        chk("md_c5_start", 64'(md_a.md_start), 64'd0);
        next();
        md_a.md_done = 1'b0;
        @(negedge clock);
        chk("md_c6_ctl", 64'(ctl_a), 64'(5'b11100));
        chk("md_c6_stall_cnt", 64'(stall_a), 64'd4);
        chk("md_c6_error", 64'(err_a), 64'd0);
        // md_done is ignored once back in RUN
        next();
        md_a.md_done = 1'b1;
        @(negedge clock);
        chk("md_done_in_run", 64'(ctl_a), 64'(5'b11100));
        md_a.md_done = 1'b0;

        // Priorities: load-use beats redirect and md issue
        do_reset();
        rmem_ex = 1'b1; wreg_ex = 1'b1; rw_ex = 5'd8; use_rs_id = 1'b1; rs_id = 5'd8;
        redirect_id = 1'b1; md_id = 1'b1;
        @(negedge clock);
        chk("prio_c0_ctl", 64'(ctl_a), 64'(5'b00110));
        next();
        rmem_ex = 1'b0; wreg_ex = 1'b0;
        @(negedge clock);
        chk("prio_c1_ctl", 64'(ctl_a), 64'(5'b11101));
        chk("prio_c1_start", 64'(md_a.md_start), 64'd0);
        next();
        idle();
        @(negedge clock);
        chk("prio_c2_start", 64'(md_a.md_start), 64'd1);
        chk("prio_c2_ctl", 64'(ctl_a), 64'(5'b00000));

        // Timeout with MD_TIMEOUT=4 and md_done never asserted
        do_reset();
        md_id = 1'b1;
        next();
        md_id = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            chk($sformatf("to_c%0d_ctl", c), 64'(ctl_b), 64'(5'b00000));
            chk($sformatf("to_c%0d_error", c), 64'(err_b), 64'd0);
            next();
        end
        @(negedge clock);
        chk("to_c5_ctl", 64'(ctl_b), 64'(5'b11100));
        chk("to_c5_error", 64'(err_b), 64'd1);
        chk("to_c5_stall_cnt", 64'(stall_b), 64'd4);
        next();
        next();
        @(negedge clock);
        chk("to_error_sticky", 64'(err_b), 64'd1);

        // Async reset while in MD_EXEC with md_start high
        next();
        md_id = 1'b1;
        next();
        md_id = 1'b0;
        @(negedge clock);
        chk("rst_pre_start", 64'(md_b.md_start), 64'd1);
        #2;
        reset_0 = 1'b0;
        #1;
        chk("rst_md_start", 64'(md_b.md_start), 64'd0);
        chk("rst_md_error", 64'(err_b), 64'd0);
        chk("rst_stall_b", 64'(stall_b), 64'd0);
        chk("rst_stall_a", 64'(stall_a), 64'd0);
        chk("rst_ctl_b", 64'(ctl_b), 64'(5'b11100));
        chk("rst_ctl_a", 64'(ctl_a), 64'(5'b11100));
        reset_0 = 1'b1;
        next();
        next();
        @(negedge clock);
        chk("rst_issue_dropped", 64'(md_b.md_start), 64'd0);
        chk("rst_run_ctl", 64'(ctl_b), 64'(5'b11100));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
